hdmi_period_scheduler: RTL
==========================

// Module: hdmi_period_scheduler
// PURPOSE
// Per-pixel sequencer for the three TMDS channel encoders. Owns the raster counters and
// syncs, and drives the encoder mode (0 control, 1 video, 2 video guard, 3 island, 4 island guard).
// Emits CTL preambles and admits data-island packets from a packet source via a pending/start handshake.
// Sits between the video timing source and the tmds_channel instances in the HDMI top.
// PARAMETERS
// H_ACTIVE 640 | H_FRONT 16 | H_SYNC 96 | H_BACK 48 : horizontal timing, pixels
// V_ACTIVE 480 | V_FRONT 10 | V_SYNC 2 | V_BACK 33 : vertical timing, lines
// ISLAND_START 4 : first island preamble pixel is at cx = H_ACTIVE+ISLAND_START (must be >= 4)
// MAX_PACKETS 18 : packets per island, maximum (1..18)
// SYNC_POL 0 : 0 = active-low hsync/vsync, 1 = active-high
// PORTS
// clk_pixel      in   1   pixel clock; the only clock
// reset_n        in   1   synchronous, active-low reset
// packet_pending in   1   level: the source has >=1 packet ready
// cx             out  12  current pixel column, 0..H_TOTAL-1
// cy             out  11  current line, 0..V_TOTAL-1
// hsync, vsync   out  1   sync levels for pixel (cx,cy), polarity set by SYNC_POL
// mode           out  3   encoder mode for pixel (cx,cy)
// ctl            out  4   {CTL3,CTL2,CTL1,CTL0}; channel 1 gets ctl[1:0], channel 2 gets ctl[3:2]
// packet_start   out  1   1-cycle pulse on the first island-data pixel of a packet; acks one packet
// packet_cycle   out  5   0..31 index within the current packet; 0 outside DI_DATA
// BEHAVIOUR
// - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK. V_TOTAL is the same sum over the V_* terms.
// - All outputs are registered and mutually aligned; encoders latch them in the same cycle.
// - Reset (reset_n=0 at an edge): cx=0, cy=V_ACTIVE, mode=0, ctl=0, packet_start=0, packet_cycle=0.
//   hsync and vsync go inactive; FSM enters CTRL. Any island in progress is abandoned, no trailing guard.
// - cx wraps at H_TOTAL-1 to 0, and cy increments; cy wraps at V_TOTAL-1 to 0.
// - Active pixel: cx<H_ACTIVE and cy<V_ACTIVE. hsync is asserted for cx in [H_ACTIVE+H_FRONT, +H_SYNC).
//   vsync is asserted for cy in [V_ACTIVE+V_FRONT, +V_SYNC).
// - FSM states: CTRL, DI_PRE, DI_LGB, DI_DATA, DI_TGB, VID_PRE, VID_GB, VIDEO.
// - VID_PRE applies when the next line is active and cx is in [H_TOTAL-10, H_TOTAL-2).
//   It outputs mode=0 and ctl=4'b0001. VID_GB covers cx H_TOTAL-2 and H_TOTAL-1 with mode=2.
//   VIDEO then outputs mode=1 for the whole active span, returning to CTRL at cx=H_ACTIVE.
// - CTRL->DI_PRE happens at cx=ISL0=H_ACTIVE+ISLAND_START, on every line, if packet_pending was 1
//   in the previous cycle. DI_PRE lasts 8 pixels with mode=0 and ctl=4'b0101.
//   DI_LGB lasts 2 pixels with mode=4. DI_DATA follows with mode=3.
// - DI_DATA consists of 32-pixel packets. packet_start pulses at packet_cycle=0.
//   Continuation is decided on the pixel where packet_cycle=31. Another packet follows only if all hold:
//   packet_pending=1, packets issued < MAX_PACKETS, and next_start+34+4 <= H_TOTAL-10.
//   Otherwise the FSM goes to DI_TGB (2 pixels, mode=4) and then CTRL with ctl=0.
// - The first packet is unconditional once DI_PRE has begun. At least 4 control pixels always separate
//   DI_TGB from VID_PRE.
// - packet_pending dropping mid-packet has no effect; the packet completes all 32 pixels.
// - ctl=0 in every state except DI_PRE and VID_PRE.
// TESTING
// - Reset mid-island (cx=700): one cycle later cx=0, cy=480, mode=0, ctl=0, packet_start=0, FSM in CTRL.
// - Line 524, default params, no packets: cx 790..797 mode=0, ctl=0001; cx 798,799 mode=2; line 0 cx 0..639 mode=1; cx 640 mode=0.
// - packet_pending=1 for one packet then 0, line 10: cx 644..651 ctl=0101; cx 652,653 mode=4.
//   Then cx 654 packet_start=1, mode=3 through cx 685; cx 686,687 mode=4; cx 688 mode=0.
// - packet_pending held 1: exactly 4 packet_start pulses at cx 654/686/718/750; mode=4 at cx 782,783; mode=0 from 784.
// - MAX_PACKETS=2, pending held 1: pulses at cx 654 and 686 only; trailing guard at cx 718,719.
// - Free-run one frame: hsync low for cx 656..751 on every line; vsync low for cy 490..491; 525 lines of 800 pixels.

Source files
------------

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel period scheduler for the TMDS encoders: raster counters, syncs,
// encoder mode, CTL preambles and data-island packet admission.
//
// state   | meaning
// CTRL    | control period, mode 0, ctl 0
// DI_PRE  | 8-pixel island preamble, ctl 0101
// DI_LGB  | 2-pixel island leading guard band
// DI_DATA | island packets, 32 pixels each
// DI_TGB  | 2-pixel island trailing guard band
// VID_PRE | 8-pixel video preamble, ctl 0001
// VID_GB  | 2-pixel video leading guard band
// VIDEO   | active video pixels
module hdmi_period_scheduler #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FRONT      = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BACK       = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FRONT      = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BACK       = 33,
   parameter int ISLAND_START = 4,
   parameter int MAX_PACKETS  = 18,
   parameter int SYNC_POL     = 0
) (
   input  logic        clk_pixel,
   input  logic        reset_n,
   input  logic        packet_pending,
   output logic [11:0] cx,
   output logic [10:0] cy,
   output logic        hsync,
   output logic        vsync,
   output logic [2:0]  mode,
   output logic [3:0]  ctl,
   output logic        packet_start,
   output logic [4:0]  packet_cycle
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [11:0] HT_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] HA      = 12'(H_ACTIVE);
   localparam logic [11:0] ISL0    = 12'(H_ACTIVE + ISLAND_START);
   localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FRONT);
   localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [11:0] VP_BEG  = 12'(H_TOTAL - 10);
   localparam logic [11:0] VG_BEG  = 12'(H_TOTAL - 2);
   localparam logic [10:0] VT_LAST = 11'(V_TOTAL - 1);
   localparam logic [10:0] VA      = 11'(V_ACTIVE);
   localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FRONT);
   localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [4:0]  MAXP    = 5'(MAX_PACKETS);
   localparam logic        SYNC_ON = (SYNC_POL != 0);

   typedef enum logic [2:0] {
      CTRL, DI_PRE, DI_LGB, DI_DATA, DI_TGB, VID_PRE, VID_GB, VIDEO
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] cx_q, cx_d;
   logic [10:0] cy_q, cy_d;
   logic [2:0]  run_q, run_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [4:0]  pc_q, pc_d;
   logic        start_q, start_d;
   logic [2:0]  mode_q, mode_d;
   logic [3:0]  ctl_q, ctl_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic [10:0] cy_after;
   logic        next_line_act;

   always_comb begin
      cx_d = (cx_q == HT_LAST) ? 12'd0 : cx_q + 12'd1;
      cy_d = cy_q;
      if (cx_q == HT_LAST)
         cy_d = (cy_q == VT_LAST) ? 11'd0 : cy_q + 11'd1;
      cy_after      = (cy_d == VT_LAST) ? 11'd0 : cy_d + 11'd1;
      next_line_act = (cy_after < VA);

      state_d = state_q;
      run_d   = 3'd0;
      cnt_d   = cnt_q;
      pc_d    = 5'd0;
      start_d = 1'b0;

      case (state_q)
         CTRL: begin
            if (cx_d == ISL0 && packet_pending) begin
               state_d = DI_PRE;
               cnt_d   = 5'd0;
            end
         end
         DI_PRE: begin
            if (run_q == 3'd7) state_d = DI_LGB;
            else run_d = run_q + 3'd1;
         end
         DI_LGB: begin
            if (run_q == 3'd1) begin
               state_d = DI_DATA;
               start_d = 1'b1;
               cnt_d   = cnt_q + 5'd1;
            end else begin
               run_d = run_q + 3'd1;
            end
         end
         DI_DATA: begin
            pc_d = pc_q + 5'd1;
            // next packet must leave room for its 32 pixels, the trailing guard and 4 control pixels
            if (pc_q == 5'd31) begin
               if (packet_pending && cnt_q < MAXP && (cx_q + 12'd39) <= VP_BEG) begin
                  start_d = 1'b1;
                  cnt_d   = cnt_q + 5'd1;
                  pc_d    = 5'd0;
               end else begin
                  state_d = DI_TGB;
                  pc_d    = 5'd0;
               end
            end
         end
         DI_TGB: begin
            if (run_q == 3'd1) state_d = CTRL;
            else run_d = run_q + 3'd1;
         end
         default: state_d = CTRL;
      endcase

      if (cx_d < HA && cy_d < VA)
         state_d = VIDEO;
      else if (next_line_act && cx_d >= VP_BEG)
         state_d = (cx_d >= VG_BEG) ? VID_GB : VID_PRE;

      mode_d = 3'd0;
      ctl_d  = 4'b0000;
      case (state_d)
         DI_PRE:  ctl_d  = 4'b0101;
         VID_PRE: ctl_d  = 4'b0001;
         DI_LGB:  mode_d = 3'd4;
         DI_TGB:  mode_d = 3'd4;
         DI_DATA: mode_d = 3'd3;
         VID_GB:  mode_d = 3'd2;
         VIDEO:   mode_d = 3'd1;
         default: mode_d = 3'd0;
      endcase

      hs_d = (cx_d >= HS_BEG && cx_d < HS_END) ? SYNC_ON : ~SYNC_ON;
      vs_d = (cy_d >= VS_BEG && cy_d < VS_END) ? SYNC_ON : ~SYNC_ON;
   end

   always_ff @(posedge clk_pixel) begin
      if (!reset_n) begin
         state_q <= CTRL;
         cx_q    <= 12'd0;
         cy_q    <= VA;
         run_q   <= 3'd0;
         cnt_q   <= 5'd0;
         pc_q    <= 5'd0;
         start_q <= 1'b0;
         mode_q  <= 3'd0;
         ctl_q   <= 4'b0000;
         hs_q    <= ~SYNC_ON;
         vs_q    <= ~SYNC_ON;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         start_q <= start_d;
         mode_q  <= mode_d;
         ctl_q   <= ctl_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
      end
   end

   assign cx           = cx_q;
   assign cy           = cy_q;
   assign hsync        = hs_q;
   assign vsync        = vs_q;
   assign mode         = mode_q;
   assign ctl          = ctl_q;
   assign packet_start = start_q;
   assign packet_cycle = pc_q;

endmodule
